// File: rtl/ext_mem_responder_pkg.sv
// ext_mem_responder_pkg
//    Shared definitions for the external-memory databus responder:
//    databus address width and the responder FSM state type.
package ext_mem_responder_pkg;

   // Width of the byte-style databus address seen by the responder.
   localparam int IO_ADDR_W = 32;

   typedef enum logic [1:0] {
      RSP_IDLE = 2'd0,
      RSP_WAIT = 2'd1,
      RSP_RESP = 2'd2
   } rsp_state_e;

endpackage : ext_mem_responder_pkg

// File: rtl/ext_mem_bram.sv
// ext_mem_bram
//    Single-port word RAM with per-byte write enables and a registered read port.
//    The array itself is never reset; only the read-data register is.
//    Ports:
//       clk_i    clock, rising edge
//       rst_ni   asynchronous active-low reset (read-data register only)
//       en_i     access enable for this cycle
//       we_i     byte write enables; all-zero with en_i=1 performs a read
//       addr_i   word index
//       wdata_i  write data
//       rdata_o  read data; updated only by reads, holds otherwise
module ext_mem_bram #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  en_i,
   input  logic [DATA_W/8-1:0]   we_i,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);

   localparam int STRB_W = DATA_W / 8;

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] wmask;

   // Expand byte enables into a bit mask so unselected bytes keep their value.
   for (genvar k = 0; k < STRB_W; k++) begin : g_mask
      assign wmask[8*k +: 8] = {8{we_i[k]}};
   end

   always_ff @(posedge clk_i) begin
      if (en_i && (we_i != '0)) begin
         mem_q[addr_i] <= (mem_q[addr_i] & ~wmask) | (wdata_i & wmask);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdata_q <= '0;
      end else if (en_i && (we_i == '0)) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : ext_mem_bram

// File: rtl/ext_mem_responder.sv
// ext_mem_responder
//    Databus target standing in for external memory. Accepts one request at a
//    time, waits a programmable number of cycles (stretched by hold), then
//    commits the write or returns the read word with a one-cycle ready pulse.
//    Ports:
//       clk            clock, rising edge
//       rst            asynchronous active-low reset
//       latency        wait states per access, sampled when a request is accepted
//       hold           freezes the wait countdown while high
//       databus_valid  request valid (held by the initiator until ready)
//       databus_addr   byte-style address; word index taken from ADDR_LSB upward
//       databus_wdata  write data
//       databus_wstrb  byte enables; all-zero means read
//       databus_ready  registered one-cycle completion pulse
//       databus_rdata  read data, valid with ready and held otherwise
//       rd_cnt         completed reads (wraps)
//       wr_cnt         completed writes (wraps)
module ext_mem_responder
   import ext_mem_responder_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 16,
   parameter int ADDR_LSB = 1,
   parameter int LAT_W    = 4,
   parameter int CNT_W    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LAT_W-1:0]      latency,
   input  logic                  hold,
   input  logic                  databus_valid,
   input  logic [IO_ADDR_W-1:0]  databus_addr,
   input  logic [DATA_W-1:0]     databus_wdata,
   input  logic [DATA_W/8-1:0]   databus_wstrb,
   output logic                  databus_ready,
   output logic [DATA_W-1:0]     databus_rdata,
   output logic [CNT_W-1:0]      rd_cnt,
   output logic [CNT_W-1:0]      wr_cnt
);

   localparam int STRB_W = DATA_W / 8;

   rsp_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]   wstrb_q, wstrb_d;
   logic [LAT_W-1:0]    wcnt_q, wcnt_d;
   logic                ready_q, ready_d;
   logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
   logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
   logic                mem_en;
   logic                unused_addr;

   // Address bits outside the word index are ignored, so indices alias.
   assign unused_addr = ^databus_addr;

   // The RESP state is the cycle in which the RAM access is issued; the ready
   // pulse, write commit and read data all appear on the edge that leaves it.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      wcnt_d   = wcnt_q;
      ready_d  = 1'b0;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      mem_en   = 1'b0;

      case (state_q)
         RSP_IDLE: begin
            if (databus_valid) begin
               idx_d   = databus_addr[ADDR_LSB +: ADDR_W];
               wdata_d = databus_wdata;
               wstrb_d = databus_wstrb;
               wcnt_d  = latency;
               state_d = (latency == '0) ? RSP_RESP : RSP_WAIT;
            end
         end
         RSP_WAIT: begin
            if (!hold) begin
               wcnt_d = wcnt_q - LAT_W'(1);
               if (wcnt_q == LAT_W'(1)) begin
                  state_d = RSP_RESP;
               end
            end
         end
         RSP_RESP: begin
            mem_en  = 1'b1;
            ready_d = 1'b1;
            if (wstrb_q != '0) begin
               wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end else begin
               rd_cnt_d = rd_cnt_q + CNT_W'(1);
            end
            state_d = RSP_IDLE;
         end
         default: begin
            state_d = RSP_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RSP_IDLE;
         idx_q    <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         wcnt_q   <= '0;
         ready_q  <= 1'b0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         wcnt_q   <= wcnt_d;
         ready_q  <= ready_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   ext_mem_bram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_bram (
      .clk_i   (clk),
      .rst_ni  (rst),
      .en_i    (mem_en),
      .we_i    (wstrb_q),
      .addr_i  (idx_q),
      .wdata_i (wdata_q),
      .rdata_o (databus_rdata)
   );

   assign databus_ready = ready_q;
   assign rd_cnt        = rd_cnt_q;
   assign wr_cnt        = wr_cnt_q;

endmodule : ext_mem_responder
